// File: rtl/iiitb_bcd_addsub.sv
// -----------------------------------------------------------------------------
// iiitb_bcd_addsub
//   Digit-serial packed-BCD adder/subtractor. Operands of DIGITS decimal digits
//   are captured in one cycle, then processed one digit per clock, least
//   significant digit first. The result, decimal carry/borrow and an operand
//   validity flag are presented behind an output valid/ready handshake.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. in_ready is high only in IDLE, so at most one operation is in
//   flight. Once out_valid is high it stays high, with sum/carry/err stable,
//   until the edge where out_ready is also high. in_valid while in_ready is
//   low is ignored, and out_ready outside DONE is ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set present
//   in_ready   block can accept operands (IDLE only)
//   a, b       packed BCD operands, digit i at [4i+3:4i]
//   sub        0: A+B+carry_in   1: A-B-carry_in
//   carry_in   carry-in (add) or borrow-in (sub)
//   out_valid  result valid, held until accepted
//   out_ready  downstream accepts result
//   sum        packed BCD result
//   carry      decimal carry-out (add) or borrow-out (sub)
//   err        some digit of a or b was above 9 at capture
//   dbg_state  current FSM state (0 IDLE, 1 CALC, 2 DONE)
// -----------------------------------------------------------------------------
module iiitb_bcd_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  sub,
  input  logic                  carry_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_sub;
  logic            r_c;        // running decimal carry between digits
  logic [CW-1:0]   r_cnt;      // index of the digit being processed
  logic [W-1:0]    r_acc;      // result digits built up during CALC
  logic            r_err_cap;  // operand check result from capture time
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic            r_err;

  logic            w_cap_err;
  logic [3:0]      w_a_dig;
  logic [3:0]      w_b_dig;
  logic [3:0]      w_bp_dig;
  logic [4:0]      w_t;
  logic            w_gt9;
  logic [3:0]      w_dig;
  logic            w_c;
  logic [W-1:0]    w_acc_next;

  // Any digit of either operand outside 0..9 flags the operation.
  always_comb begin
    w_cap_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
        w_cap_err = 1'b1;
      end
    end
  end

  // Select the current digit pair from the captured operands.
  always_comb begin
    w_a_dig = 4'd0;
    w_b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_cnt == CW'(i)) begin
        w_a_dig = r_a[4*i +: 4];
        w_b_dig = r_b[4*i +: 4];
      end
    end
  end

  // Subtraction adds the nine's complement of B; the inverted initial carry
  // and inverted final carry turn that into ten's-complement with borrow.
  // For out-of-range B digits the 4-bit subtraction simply wraps.
  always_comb begin
    w_bp_dig = r_sub ? (4'd9 - w_b_dig) : w_b_dig;
    w_t      = {1'b0, w_a_dig} + {1'b0, w_bp_dig} + {4'd0, r_c};
    w_gt9    = (w_t > 5'd9);
    w_dig    = w_gt9 ? (w_t[3:0] + 4'd6) : w_t[3:0];
    w_c      = w_gt9;
  end

  always_comb begin
    w_acc_next = r_acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_cnt == CW'(i)) begin
        w_acc_next[4*i +: 4] = w_dig;
      end
    end
  end

  // Results are published only on entry to DONE, so sum/carry/err stay
  // constant while the next operation is being computed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sub     <= 1'b0;
      r_c       <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_err_cap <= 1'b0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a       <= a;
            r_b       <= b;
            r_sub     <= sub;
            r_c       <= sub ? ~carry_in : carry_in;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_err_cap <= w_cap_err;
            r_state   <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= w_acc_next;
          r_c   <= w_c;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_sum   <= w_acc_next;
            r_carry <= r_sub ? ~w_c : w_c;
            r_err   <= r_err_cap;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_iiitb_bcd_addsub.sv
// -----------------------------------------------------------------------------
// tb_iiitb_bcd_addsub
//   Self-checking bench for iiitb_bcd_addsub with DIGITS=4. Expected results
//   come from an integer decimal model and are queued at capture time, then
//   popped when the DUT raises out_valid. Inputs change and outputs are
//   sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_iiitb_bcd_addsub;

  localparam int D = 4;
  localparam int W = 4 * D;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sub;
  logic          carry_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          carry;
  logic          err;
  logic [1:0]    dbg_state;

  iiitb_bcd_addsub #(.DIGITS(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W+1:0] exp_q[$];   // {err, carry, sum}
  bit           full_q[$];  // 1: sum/carry defined (operands valid)
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r;
    r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r;
    longint       x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [W+1:0] model(input logic [W-1:0] ma,
                                         input logic [W-1:0] mb,
                                         input logic ms, input logic mc);
    longint m;
    longint r;
    logic   cy;
    logic   e;
    m = 1;
    for (int i = 0; i < D; i++) m = m * 10;
    e = 1'b0;
    for (int i = 0; i < D; i++)
      if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) e = 1'b1;
    if (!ms) begin
      r  = bcd2int(ma) + bcd2int(mb) + longint'(mc);
      cy = (r >= m);
      r  = r % m;
    end else begin
      r  = bcd2int(ma) - bcd2int(mb) - longint'(mc);
      cy = (r < 0);
      if (cy) r = r + m;
    end
    return {e, cy, int2bcd(r)};
  endfunction

  // ---------------- driver tasks ----------------
  // Collect one result: optionally stall out_ready for 'hold' cycles while
  // poking in_valid, then compare against the queue and accept.
  task automatic collect(input int hold);
    logic [W+1:0] e;
    bit           f;
    logic [W-1:0] s0;
    logic         c0;
    check_eq("q_nonempty", (exp_q.size() != 0), 1'b1);
    if (exp_q.size() == 0) return;
    e  = exp_q.pop_front();
    f  = full_q.pop_front();
    s0 = sum;
    c0 = carry;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = W'($urandom);
      b         = W'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("hold_out_valid", out_valid, 1'b1);
      check_eq("hold_in_ready", in_ready, 1'b0);
      check_eq("hold_sum", sum, s0);
      check_eq("hold_carry", carry, c0);
    end
    if (f) begin
      check_eq("sum", sum, e[W-1:0]);
      check_eq("carry", carry, e[W]);
    end
    check_eq("err", err, e[W+1]);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_out_valid", out_valid, 1'b0);
    check_eq("post_in_ready", in_ready, 1'b1);
    check_eq("post_sum_held", sum, s0);
  endtask

  // Issue one operation; called at a falling edge. With push=0 the operation
  // is not scoreboarded and the task returns right after capture.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic ts, input logic tc, input int hold,
                        input bit push, output int waited);
    int lat;
    a        = ta;
    b        = tb_;
    sub      = ts;
    carry_in = tc;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq("in_ready_wait", in_ready, 1'b1);
    if (push) begin
      exp_q.push_back(model(ta, tb_, ts, tc));
      full_q.push_back(model(ta, tb_, ts, tc) >> (W + 1) == 0);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (!push) return;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", lat, D);
    collect(hold);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    logic [W-1:0] ra, rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    carry_in  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_sum", sum, '0);
    check_eq("rst_carry", carry, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 0, 1'b1, w);
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 0, 1'b1, w);
    run_op(16'h9999, 16'h9999, 1'b0, 1'b1, 1, 1'b1, w);
    run_op(16'h5000, 16'h1234, 1'b1, 1'b0, 0, 1'b1, w);
    run_op(16'h0000, 16'h0001, 1'b1, 1'b0, 0, 1'b1, w);
    run_op(16'h0005, 16'h0005, 1'b1, 1'b1, 2, 1'b1, w);
    run_op(16'h00A0, 16'h0001, 1'b0, 1'b0, 0, 1'b1, w);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 3, 1'b1, w);
    // Immediately after acceptance: must be captured without waiting.
    run_op(16'h0123, 16'h0456, 1'b0, 1'b0, 0, 1'b1, w);
    check_eq("b2b_no_wait", w, 0);

    // Abort mid-CALC with an asynchronous reset.
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 0, 1'b0, w);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", out_valid, 1'b0);
    check_eq("abort_sum", sum, '0);
    check_eq("abort_in_ready", in_ready, 1'b1);
    check_eq("abort_state", dbg_state, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'h0019, 16'h0001, 1'b0, 1'b0, 0, 1'b1, w);

    // Random valid operations.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < D; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)), 1'b1, w);
    end

    check_eq("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
